hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined RISC-V datapath. It replaces the fixed three-stage forwarding logic and the ad-hoc skip handling.
- Tracks the destination register of every in-flight instruction through a shift register of DEPTH post-decode stages.
- Produces forwarded operand values, a load-use stall and a qualified register-file write enable.
- Sits in decode. It is fed by the decoder, the register file and the per-stage result buses.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register address width.
- DEPTH, 3, number of tracked stages after decode (1 = ex, DEPTH = wb). Must be >= 2.
- LOAD_READY_STAGE, 2, first stage at which load data is valid on stage_data. Range 1..DEPTH.
- NUM_SRC, 2, number of source operands.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active low
- hold  in  1  freeze whole tracker (downstream busy)
- flush  in  1  kill stage-1 entry and the current issue
- issue_valid  in  1  decode instruction is issuing
- issue_rd_addr  in  REG_ADDR_W  destination register
- issue_wen  in  1  instruction writes rd
- issue_from_mem  in  1  rd comes from a load
- src_addr  in  NUM_SRC*REG_ADDR_W  source addresses; slice i = source i
- src_use  in  NUM_SRC  source i is read
- src_reg  in  NUM_SRC*XLEN  register-file read values
- stage_data  in  DEPTH*XLEN  result of the instruction in stage k, on slice k-1
- src_val  out  NUM_SRC*XLEN  resolved operand values
- src_fwd  out  NUM_SRC  source i was forwarded
- stall  out  1  load-use stall
- wb_valid  out  1  stage-DEPTH entry valid
- wb_rd_addr  out  REG_ADDR_W  stage-DEPTH destination
- wb_en  out  1  register-file write enable
- stall_cycles  out  32  saturating stall counter

Behaviour:
- Entry contents: {valid, rd_addr, wen, from_mem}, one per stage 1..DEPTH.
- Reset: the interface is one clock, synchronous active-low reset. On rst=0 at a rising edge:
  - all entries become invalid and stall_cycles becomes 0;
  - outputs then read stall=0, src_fwd=0, src_val=src_reg, wb_valid=0, wb_en=0, wb_rd_addr=0;
  - a reset mid-operation discards all in-flight entries.
- Shift (hold=0): stage k+1 <= stage k, and stage 1 <= new entry.
  - New entry = issue fields with valid=issue_valid & ~stall & ~flush; otherwise a bubble.
  - An instruction issued at edge t is in stage k during cycle t+k.
- Hold (hold=1): no entry changes, stall_cycles is unchanged, and flush is ignored. Upstream keeps flush asserted until hold drops.
- Flush (hold=0): the stage-1 entry is invalidated instead of advancing, so stage 2 receives a bubble, and stage 1 <= bubble. Older stages advance normally.
- Match rule: source i matches stage k when src_use[i], entry valid, wen=1, rd_addr==src_addr[i], and src_addr[i]!=0. x0 never matches.
- Priority: the youngest matching stage (lowest k) wins.
- Forwarding: if the winning stage is forwardable, src_val[i]=stage_data[k] and src_fwd[i]=1. Otherwise src_val[i]=src_reg[i] and src_fwd[i]=0.
  - A stage is forwardable if it is not a load, or it is a load with k >= LOAD_READY_STAGE.
  - Combinational, zero latency.
- Stall: stall=1 when any source's winning stage is a load with k < LOAD_READY_STAGE.
  - The stall is combinational.
  - Decode must hold its instruction; the scoreboard inserts a bubble.
  - The stall clears automatically once the load reaches LOAD_READY_STAGE (1 cycle with defaults).
- Writeback: wb_en = wb_valid & wen & (wb_rd_addr!=0). The register-file write happens at the end of that cycle. Stage DEPTH remains forwardable, so no read-after-write gap exists.
- stall_cycles: increments on each edge with rst=1, hold=0, stall=1. It saturates at 0xFFFFFFFF.
- Simultaneous stall and flush: flush dominates and stage 1 gets a bubble. stall_cycles still counts if stall=1.

Test Plan:
- ALU forwarding: issue add x5 at t; at t+1, src0 = x5 with src_use, stage_data[1]=0x00001234, src_reg=0 -> src_val0=0x00001234, src_fwd0=1, stall=0.
- Load-use: issue lw x6 (from_mem) at t; at t+1, src1 = x6 -> stall=1 for one cycle and stage 1 becomes a bubble; at t+2, stage_data[2]=0xDEADBEEF -> src_val1=0xDEADBEEF, stall=0, stall_cycles=1.
- Priority: x7 in stage 3 (stage_data=0x1) and stage 1 (stage_data=0x2), read x7 -> src_val=0x2.
- x0: issue wen to x0, then read x0 with src_reg=0 -> src_fwd=0, src_val=0; three cycles later wb_valid=1, wb_en=0.
- Hold/flush: with entries in stages 1..3, hold=1 for 2 cycles -> wb_rd_addr constant and no shift; then flush=1 with hold=0 -> the stage-1 entry never produces wb_valid.
- Reset mid-flight: load in stage 1, stall_cycles=5, rst=0 for one edge -> all entries invalid, stall=0, stall_cycles=0, wb_en=0 for the next DEPTH cycles absent new issues.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: forwarding and load-use hazard unit sitting in decode.
// Tracks {valid, rd_addr, wen, from_mem} for each of DEPTH post-decode stages
// (index 0 = stage 1 = ex, index DEPTH-1 = wb).
// Ports:
//   clk, rst (sync, active low), hold (freeze tracker), flush (kill stage 1 + issue)
//   issue_*     : instruction leaving decode
//   src_*       : source operand addresses, use flags, register-file values
//   stage_data  : per-stage result buses, slice k-1 = stage k
//   src_val/src_fwd : resolved operands and forwarded flags
//   stall       : load-use stall (combinational)
//   wb_*        : stage-DEPTH entry and qualified register-file write enable
//   stall_cycles: saturating count of stalled, non-held cycles
module hazard_scoreboard #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned REG_ADDR_W       = 5,
  parameter int unsigned DEPTH            = 3,
  parameter int unsigned LOAD_READY_STAGE = 2,
  parameter int unsigned NUM_SRC          = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd_addr,
  input  logic                          issue_wen,
  input  logic                          issue_from_mem,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC-1:0]            src_use,
  input  logic [NUM_SRC*XLEN-1:0]       src_reg,
  input  logic [DEPTH*XLEN-1:0]         stage_data,
  output logic [NUM_SRC*XLEN-1:0]       src_val,
  output logic [NUM_SRC-1:0]            src_fwd,
  output logic                          stall,
  output logic                          wb_valid,
  output logic [REG_ADDR_W-1:0]         wb_rd_addr,
  output logic                          wb_en,
  output logic [31:0]                   stall_cycles
);

  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [DEPTH-1:0]                 wen_q, wen_d;
  logic [DEPTH-1:0]                 mem_q, mem_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [31:0]                      stall_cycles_q, stall_cycles_d;
  logic                             issue_ok;

  // Operand resolution: youngest matching stage wins; an unready load stalls.
  always_comb begin
    src_val = src_reg;
    src_fwd = '0;
    stall   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic                  hit;
      int unsigned           hit_k;
      logic [REG_ADDR_W-1:0] addr;
      hit   = 1'b0;
      hit_k = 0;
      addr  = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!hit && src_use[i] && valid_q[k] && wen_q[k] && (rd_q[k] == addr) &&
            (addr != '0)) begin
          hit   = 1'b1;
          hit_k = k;
        end
      end
      if (hit) begin
        // hit_k is 0-based, stage number is hit_k + 1
        if (mem_q[hit_k] && (hit_k + 1 < LOAD_READY_STAGE)) begin
          stall = 1'b1;
        end else begin
          src_val[i*XLEN +: XLEN] = stage_data[hit_k*XLEN +: XLEN];
          src_fwd[i]              = 1'b1;
        end
      end
    end
  end

  assign issue_ok = issue_valid & ~stall & ~flush;

  always_comb begin
    valid_d        = valid_q;
    wen_d          = wen_q;
    mem_d          = mem_q;
    rd_d           = rd_q;
    stall_cycles_d = stall_cycles_q;
    if (!hold) begin
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_d = stall_cycles_q + 32'd1;
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        wen_d[k]   = wen_q[k-1];
        mem_d[k]   = mem_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
      // Flushed stage-1 entry turns into a bubble instead of advancing.
      if (flush) begin
        valid_d[1] = 1'b0;
        wen_d[1]   = 1'b0;
        mem_d[1]   = 1'b0;
        rd_d[1]    = '0;
      end
      valid_d[0] = issue_ok;
      wen_d[0]   = issue_ok & issue_wen;
      mem_d[0]   = issue_ok & issue_from_mem;
      rd_d[0]    = issue_ok ? issue_rd_addr : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q        <= '0;
      wen_q          <= '0;
      mem_q          <= '0;
      rd_q           <= '0;
      stall_cycles_q <= '0;
    end else begin
      valid_q        <= valid_d;
      wen_q          <= wen_d;
      mem_q          <= mem_d;
      rd_q           <= rd_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign wb_valid     = valid_q[DEPTH-1];
  assign wb_rd_addr   = rd_q[DEPTH-1];
  assign wb_en        = valid_q[DEPTH-1] & wen_q[DEPTH-1] & (rd_q[DEPTH-1] != '0);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written reset
// sequence, then randomized traffic against a stage-array reference model.
module tb_hazard_scoreboard;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned LRS  = 2;
  localparam int unsigned NSRC = 2;

  localparam logic [31:0] RA = 32'hA0A0_A0A0;
  localparam logic [31:0] RB = 32'hB1B1_B1B1;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;

  logic                   clk = 1'b0;
  logic                   rst, hold, flush, issue_valid, issue_wen, issue_from_mem;
  logic [AW-1:0]          issue_rd_addr;
  logic [NSRC*AW-1:0]     src_addr;
  logic [NSRC-1:0]        src_use;
  logic [NSRC*XLEN-1:0]   src_reg;
  logic [DEPTH*XLEN-1:0]  stage_data;
  logic [NSRC*XLEN-1:0]   src_val;
  logic [NSRC-1:0]        src_fwd;
  logic                   stall, wb_valid, wb_en;
  logic [AW-1:0]          wb_rd_addr;
  logic [31:0]            stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .XLEN(XLEN), .REG_ADDR_W(AW), .DEPTH(DEPTH), .LOAD_READY_STAGE(LRS), .NUM_SRC(NSRC)
  ) dut (
    .clk(clk), .rst(rst), .hold(hold), .flush(flush), .issue_valid(issue_valid),
    .issue_rd_addr(issue_rd_addr), .issue_wen(issue_wen), .issue_from_mem(issue_from_mem),
    .src_addr(src_addr), .src_use(src_use), .src_reg(src_reg), .stage_data(stage_data),
    .src_val(src_val), .src_fwd(src_fwd), .stall(stall), .wb_valid(wb_valid),
    .wb_rd_addr(wb_rd_addr), .wb_en(wb_en), .stall_cycles(stall_cycles)
  );

  // Reference model: one record per stage, stage 1 = youngest.
  typedef struct {
    bit            v;
    logic [AW-1:0] rd;
    bit            wen;
    bit            mem;
  } ent_t;
  ent_t   m [1:DEPTH];
  longint m_cnt;

  function automatic void model_out(output logic [63:0] val, output logic [1:0] fwd,
                                    output logic stl);
    val = src_reg;
    fwd = 2'b00;
    stl = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [AW-1:0] a;
      a = src_addr[i*AW +: AW];
      if (src_use[i] && a != 0) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (m[k].v && m[k].wen && m[k].rd == a) begin
            if (m[k].mem && k < LRS) stl = 1'b1;
            else begin
              val[i*32 +: 32] = stage_data[(k-1)*32 +: 32];
              fwd[i] = 1'b1;
            end
            break;
          end
        end
      end
    end
  endfunction

  task automatic apply_edge();
    logic [63:0] v;
    logic [1:0]  f;
    logic        s;
    model_out(v, f, s);
    @(posedge clk);
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) m[k] = '{0, 0, 0, 0};
      m_cnt = 0;
    end else if (!hold) begin
      if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      for (int k = DEPTH; k >= 2; k--) m[k] = m[k-1];
      if (flush) m[2] = '{0, 0, 0, 0};
      m[1] = '{issue_valid && !s && !flush, issue_rd_addr, issue_wen, issue_from_mem};
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hold = 0; flush = 0; issue_valid = 0; issue_rd_addr = 0; issue_wen = 0;
    issue_from_mem = 0; src_addr = 0; src_use = 0; src_reg = {RB, RA};
    stage_data = {D3, D2, D1};
  endtask

  typedef struct {
    logic [2:0]  ctl;   // {hold, flush, issue_valid}
    logic [4:0]  ird;
    logic [1:0]  im;    // {wen, from_mem}
    logic [4:0]  a0, a1;
    logic [1:0]  suse;
    logic [31:0] r0, r1, d1, d2, d3;
    logic [31:0] ev0, ev1;
    logic [1:0]  efwd;
    logic        est, ewbv, ewben;
    logic [4:0]  ewbrd;
    logic [31:0] ecnt;
  } vec_t;
  vec_t tbl [26];

  initial begin
    logic [63:0] ev;
    logic [1:0]  ef;
    logic        es;
    // ALU forwarding
    tbl[0]  = '{3'b001, 5'd5, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    tbl[1]  = '{3'b000, 5'd0, 2'b00, 5'd5, 5'd0, 2'b01, 32'd0, RB, 32'h1234, D2, D3,
                32'h1234, RB, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    // Load-use: stall one cycle, then forward from stage 2
    tbl[2]  = '{3'b001, 5'd6, 2'b11, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0};
    tbl[3]  = '{3'b001, 5'd9, 2'b10, 5'd0, 5'd6, 2'b10, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b1, 1'b1, 1'b1, 5'd5, 32'd0};
    tbl[4]  = '{3'b001, 5'd9, 2'b10, 5'd0, 5'd6, 2'b10, RA, RB, D1, 32'hDEAD_BEEF, D3,
                RA, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    // Priority: x7 in stages 1 and 3
    tbl[5]  = '{3'b001, 5'd7, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd6, 32'd1};
    tbl[6]  = '{3'b001, 5'd8, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[7]  = '{3'b001, 5'd7, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd9, 32'd1};
    tbl[8]  = '{3'b000, 5'd0, 2'b00, 5'd7, 5'd8, 2'b11, RA, RB, 32'h2, 32'h33, 32'h1,
                32'h2, 32'h33, 2'b11, 1'b0, 1'b1, 1'b1, 5'd7, 32'd1};
    // x0 never matches, writeback disabled
    tbl[9]  = '{3'b001, 5'd0, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd8, 32'd1};
    tbl[10] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, 32'd0, RB, D1, D2, D3,
                32'd0, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd7, 32'd1};
    tbl[11] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[12] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 32'd1};
    // Hold then flush
    tbl[13] = '{3'b001, 5'd10, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[14] = '{3'b001, 5'd11, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[15] = '{3'b001, 5'd12, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[16] = '{3'b100, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd10, 32'd1};
    tbl[17] = '{3'b100, 5'd0, 2'b00, 5'd12, 5'd0, 2'b01, RA, RB, D1, D2, D3,
                D1, RB, 2'b01, 1'b0, 1'b1, 1'b1, 5'd10, 32'd1};
    tbl[18] = '{3'b011, 5'd13, 2'b10, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd10, 32'd1};
    tbl[19] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b1, 1'b1, 5'd11, 32'd1};
    tbl[20] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    // Stall and flush together: flush wins, counter still counts
    tbl[21] = '{3'b001, 5'd14, 2'b11, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[22] = '{3'b011, 5'd15, 2'b10, 5'd14, 5'd0, 2'b01, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0, 32'd1};
    tbl[23] = '{3'b000, 5'd0, 2'b00, 5'd14, 5'd0, 2'b01, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd2};
    tbl[24] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd2};
    tbl[25] = '{3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, RA, RB, D1, D2, D3,
                RA, RB, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'd2};

    idle();
    rst = 1'b0;
    apply_edge();
    apply_edge();
    rst = 1'b1;
    src_addr = {5'd3, 5'd3};
    src_use  = 2'b11;
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_fwd", src_fwd, 2'b00);
    chk("rst_val", src_val, src_reg);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_wben", wb_en, 1'b0);
    chk("rst_wbrd", wb_rd_addr, 5'd0);
    chk("rst_cnt", stall_cycles, 32'd0);
    apply_edge();

    for (int j = 0; j < 26; j++) begin
      {hold, flush, issue_valid} = tbl[j].ctl;
      issue_rd_addr = tbl[j].ird;
      {issue_wen, issue_from_mem} = tbl[j].im;
      src_addr   = {tbl[j].a1, tbl[j].a0};
      src_use    = tbl[j].suse;
      src_reg    = {tbl[j].r1, tbl[j].r0};
      stage_data = {tbl[j].d3, tbl[j].d2, tbl[j].d1};
      @(negedge clk);
      chk($sformatf("v%0d_val", j), src_val, {tbl[j].ev1, tbl[j].ev0});
      chk($sformatf("v%0d_fwd", j), src_fwd, tbl[j].efwd);
      chk($sformatf("v%0d_stall", j), stall, tbl[j].est);
      chk($sformatf("v%0d_wbv", j), wb_valid, tbl[j].ewbv);
      chk($sformatf("v%0d_wben", j), wb_en, tbl[j].ewben);
      if (tbl[j].ewbv) chk($sformatf("v%0d_wbrd", j), wb_rd_addr, tbl[j].ewbrd);
      chk($sformatf("v%0d_cnt", j), stall_cycles, tbl[j].ecnt);
      apply_edge();
    end

    // Build stall_cycles up to 5 with three load-use pairs
    for (int r = 0; r < 3; r++) begin
      idle();
      issue_valid = 1; issue_rd_addr = 5'd6; issue_wen = 1; issue_from_mem = 1;
      apply_edge();
      idle();
      src_addr = {5'd6, 5'd0}; src_use = 2'b10;
      @(negedge clk);
      chk("lu_stall", stall, 1'b1);
      apply_edge();
      idle();
      apply_edge();
    end
    @(negedge clk);
    chk("cnt5", stall_cycles, 32'd5);
    // Reset with a load sitting in stage 1
    issue_valid = 1; issue_rd_addr = 5'd6; issue_wen = 1; issue_from_mem = 1;
    apply_edge();
    idle();
    src_addr = {5'd6, 5'd6}; src_use = 2'b11;
    @(negedge clk);
    chk("pre_rst_stall", stall, 1'b1);
    rst = 1'b0;
    apply_edge();
    rst = 1'b1;
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      chk("mrst_stall", stall, 1'b0);
      chk("mrst_fwd", src_fwd, 2'b00);
      chk("mrst_cnt", stall_cycles, 32'd0);
      chk("mrst_wbv", wb_valid, 1'b0);
      chk("mrst_wben", wb_en, 1'b0);
      apply_edge();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) != 0);
      hold           = ($urandom_range(0, 7) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      issue_valid    = $urandom_range(0, 1) == 1;
      issue_rd_addr  = 5'($urandom_range(0, 7));
      issue_wen      = ($urandom_range(0, 4) != 0);
      issue_from_mem = ($urandom_range(0, 2) == 0);
      src_addr       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      src_use        = 2'($urandom);
      src_reg        = {$urandom, $urandom};
      stage_data     = {$urandom, $urandom, $urandom};
      @(negedge clk);
      model_out(ev, ef, es);
      chk("rnd_val", src_val, ev);
      chk("rnd_fwd", src_fwd, ef);
      chk("rnd_stall", stall, es);
      chk("rnd_wbv", wb_valid, m[DEPTH].v);
      chk("rnd_wben", wb_en, m[DEPTH].v && m[DEPTH].wen && m[DEPTH].rd != 0);
      if (m[DEPTH].v) chk("rnd_wbrd", wb_rd_addr, m[DEPTH].rd);
      chk("rnd_cnt", stall_cycles, m_cnt);
      apply_edge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
